// File: rtl/peak_report_packer_if.sv
// Frame-end snapshot inputs and AXI-Stream result port of the peak report packer.
interface peak_report_packer_if #(
   parameter int unsigned NUM_PEAKS   = 4,
   parameter int unsigned VALUE_WIDTH = 16,
   parameter int unsigned INDEX_WIDTH = 12,
   parameter int unsigned DATA_WIDTH  = 32
);
   logic                             last_in;
   logic [NUM_PEAKS*VALUE_WIDTH-1:0] peaks_in;
   logic [NUM_PEAKS*INDEX_WIDTH-1:0] indices_in;
   logic [DATA_WIDTH-1:0]            m_tdata;
   logic                             m_tvalid;
   logic                             m_tready;
   logic                             m_tlast;
   logic                             busy;
   logic [15:0]                      frame_count;
   logic [15:0]                      overrun_count;

   modport master (
      input  last_in, peaks_in, indices_in, m_tready,
      output m_tdata, m_tvalid, m_tlast, busy, frame_count, overrun_count
   );

   modport slave (
      output last_in, peaks_in, indices_in, m_tready,
      input  m_tdata, m_tvalid, m_tlast, busy, frame_count, overrun_count
   );
endinterface

// File: rtl/peak_report_packer.sv
// Snapshots a frame of peaks/indices on last_in and streams them as a
// header beat plus one beat per peak on an AXI-Stream master port.
module peak_report_packer #(
   parameter int unsigned NUM_PEAKS   = 4,
   parameter int unsigned VALUE_WIDTH = 16,
   parameter int unsigned INDEX_WIDTH = 12,
   parameter int unsigned DATA_WIDTH  = 32
) (
   input logic                  clk,
   input logic                  reset,
   peak_report_packer_if.master bus
);
   localparam int unsigned        K_WIDTH   = (NUM_PEAKS > 1) ? $clog2(NUM_PEAKS) : 1;
   localparam logic [K_WIDTH-1:0] K_LAST    = K_WIDTH'(NUM_PEAKS - 1);
   localparam logic [7:0]         SYNC_BYTE = 8'hA5;

   typedef enum logic [1:0] {IDLE, HEADER, PEAK} state_t;

   state_t                 r_state;
   logic [K_WIDTH-1:0]     r_k;
   logic [VALUE_WIDTH-1:0] r_peak  [NUM_PEAKS];
   logic [INDEX_WIDTH-1:0] r_index [NUM_PEAKS];
   logic [DATA_WIDTH-1:0]  r_tdata;
   logic                   r_tvalid;
   logic                   r_tlast;
   logic                   r_busy;
   logic [15:0]            r_frame_count;
   logic [15:0]            r_overrun_count;

   logic                   w_xfer;
   logic                   w_overrun;
   logic [K_WIDTH-1:0]     w_next_k;
   logic [DATA_WIDTH-1:0]  w_next_beat;

   // Beat to present after the current transfer: peak 0 after the header, else k+1.
   assign w_xfer      = r_tvalid & bus.m_tready;
   assign w_overrun   = bus.last_in & (r_state != IDLE);
   assign w_next_k    = (r_state == HEADER) ? '0 : r_k + K_WIDTH'(1);
   assign w_next_beat = DATA_WIDTH'({r_index[w_next_k], r_peak[w_next_k]});

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state         <= IDLE;
         r_k             <= '0;
         r_tdata         <= '0;
         r_tvalid        <= 1'b0;
         r_tlast         <= 1'b0;
         r_busy          <= 1'b0;
         r_frame_count   <= '0;
         r_overrun_count <= '0;
         for (int i = 0; i < NUM_PEAKS; i++) begin
            r_peak[i]  <= '0;
            r_index[i] <= '0;
         end
      end else begin
         // A frame end arriving while a packet is held or in flight is dropped.
         if (w_overrun && (r_overrun_count != 16'hFFFF))
            r_overrun_count <= r_overrun_count + 16'd1;

         case (r_state)
            IDLE: begin
               if (bus.last_in) begin
                  for (int i = 0; i < NUM_PEAKS; i++) begin
                     r_peak[i]  <= bus.peaks_in[i*VALUE_WIDTH +: VALUE_WIDTH];
                     r_index[i] <= bus.indices_in[i*INDEX_WIDTH +: INDEX_WIDTH];
                  end
                  r_tdata       <= DATA_WIDTH'({r_frame_count, 8'(NUM_PEAKS), SYNC_BYTE});
                  r_frame_count <= r_frame_count + 16'd1;
                  r_tvalid      <= 1'b1;
                  r_tlast       <= 1'b0;
                  r_busy        <= 1'b1;
                  r_state       <= HEADER;
               end
            end
            HEADER: begin
               if (w_xfer) begin
                  r_k     <= '0;
                  r_tdata <= w_next_beat;
                  r_tlast <= (K_LAST == '0);
                  r_state <= PEAK;
               end
            end
            PEAK: begin
               if (w_xfer) begin
                  if (r_k == K_LAST) begin
                     r_state  <= IDLE;
                     r_tvalid <= 1'b0;
                     r_tlast  <= 1'b0;
                     r_busy   <= 1'b0;
                     r_tdata  <= '0;
                  end else begin
                     r_k     <= w_next_k;
                     r_tdata <= w_next_beat;
                     r_tlast <= (w_next_k == K_LAST);
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.m_tdata       = r_tdata;
   assign bus.m_tvalid      = r_tvalid;
   assign bus.m_tlast       = r_tlast;
   assign bus.busy          = r_busy;
   assign bus.frame_count   = r_frame_count;
   assign bus.overrun_count = r_overrun_count;
endmodule
